// File: rtl/artec_sync_frame_dispatch.sv
`timescale 1ns/1ps
// Turns each synced frame number into one read command per enabled capture channel,
// then waits for every command to complete before accepting the next sync.
module artec_sync_frame_dispatch #(
  parameter int unsigned CH_NUM = 5,
  parameter int unsigned FB_NUM = 8,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned FN_W = $clog2(FB_NUM),
  localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int unsigned OC_W = $clog2(CH_NUM + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CH_NUM-1:0]        ch_enable_i,
  input  logic [CH_NUM*ADDR_W-1:0] ch_base_i,
  input  logic [ADDR_W-1:0]        frame_size_i,
  input  logic                     sync_valid_i,
  input  logic [FN_W-1:0]          sync_fnum_i,
  output logic                     sync_ready_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [CH_W-1:0]          cmd_ch_o,
  output logic [ADDR_W-1:0]        cmd_addr_o,
  output logic [ADDR_W-1:0]        cmd_len_o,
  input  logic                     done_i,
  output logic                     busy_o,
  output logic [15:0]              frame_cnt_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [CH_NUM-1:0]   pend_q, pend_clr, sel_pend;
  logic [FN_W-1:0]     fnum_q, sel_fnum;
  logic [OC_W-1:0]     oc_q, oc_d;
  logic                cmd_valid_q, busy_q, err_q;
  logic [CH_W-1:0]     cmd_ch_q, sel_ch;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_len_q, sel_base, sel_addr;
  logic [15:0]         frame_cnt_q;
  logic                hs, accept, load, frame_done, cmd_fire, err_set;

  assign sync_ready_o = (state_q == IDLE);
  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_ch_o     = cmd_ch_q;
  assign cmd_addr_o   = cmd_addr_q;
  assign cmd_len_o    = cmd_len_q;
  assign busy_o       = busy_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign err_o        = err_q;

  assign cmd_fire = cmd_valid_q && cmd_ready_i;
  assign pend_clr = pend_q & ~(CH_NUM'(1) << cmd_ch_q);

  // Outstanding-command bookkeeping; simultaneous accept and done cancel out.
  always_comb begin
    oc_d    = oc_q;
    err_set = 1'b0;
    if (cmd_fire && !done_i) begin
      oc_d = oc_q + OC_W'(1);
    end else if (done_i && !cmd_fire) begin
      if (oc_q == '0) err_set = 1'b1;
      else            oc_d = oc_q - OC_W'(1);
    end
  end

  // Next-state logic; the next command is loaded in the same cycle the previous one is taken.
  always_comb begin
    state_d    = state_q;
    hs         = 1'b0;
    accept     = 1'b0;
    load       = 1'b0;
    frame_done = 1'b0;
    sel_pend   = pend_clr;
    sel_fnum   = fnum_q;
    case (state_q)
      IDLE: begin
        sel_pend = ch_enable_i;
        sel_fnum = sync_fnum_i;
        if (sync_valid_i) begin
          hs = 1'b1;
          if (|ch_enable_i) begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cmd_fire) begin
          accept = 1'b1;
          if (|pend_clr) load = 1'b1;
          else           state_d = WAIT;
        end
      end
      WAIT: begin
        if (oc_d == '0) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lowest pending channel and its buffer address for the next command.
  always_comb begin
    sel_ch   = '0;
    sel_base = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (sel_pend[i]) begin
        sel_ch   = CH_W'(i);
        sel_base = ch_base_i[i*ADDR_W +: ADDR_W];
      end
    end
    sel_addr = sel_base + ADDR_W'(sel_fnum) * frame_size_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q      <= '0;
      fnum_q      <= '0;
      oc_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (hs) begin
        pend_q <= ch_enable_i;
        fnum_q <= sync_fnum_i;
      end else if (accept) begin
        pend_q <= pend_clr;
      end
      if (load) begin
        cmd_valid_q <= 1'b1;
        cmd_ch_q    <= sel_ch;
        cmd_addr_q  <= sel_addr;
        cmd_len_q   <= frame_size_i;
      end else if (accept) begin
        cmd_valid_q <= 1'b0;
      end
      oc_q   <= oc_d;
      busy_q <= (state_d != IDLE);
      if (err_set) err_q <= 1'b1;
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_artec_sync_frame_dispatch.sv
`timescale 1ns/1ps
// Randomized and directed bench for artec_sync_frame_dispatch against a transaction-level model.
module tb_artec_sync_frame_dispatch;
  localparam int unsigned CH_NUM = 5;
  localparam int unsigned FB_NUM = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned FN_W   = $clog2(FB_NUM);
  localparam int unsigned CH_W   = $clog2(CH_NUM);

  logic clk = 1'b0;
  logic rstn;
  logic [CH_NUM-1:0]        ch_enable;
  logic [CH_NUM*ADDR_W-1:0] ch_base;
  logic [ADDR_W-1:0]        frame_size;
  logic                     sync_valid, sync_ready;
  logic [FN_W-1:0]          sync_fnum;
  logic                     cmd_valid, cmd_ready;
  logic [CH_W-1:0]          cmd_ch;
  logic [ADDR_W-1:0]        cmd_addr, cmd_len;
  logic                     done, busy, err;
  logic [15:0]              frame_cnt;

  always #5 clk = ~clk;

  artec_sync_frame_dispatch #(.CH_NUM(CH_NUM), .FB_NUM(FB_NUM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .ch_enable_i(ch_enable), .ch_base_i(ch_base),
    .frame_size_i(frame_size), .sync_valid_i(sync_valid), .sync_fnum_i(sync_fnum),
    .sync_ready_o(sync_ready), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_ch_o(cmd_ch), .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len), .done_i(done),
    .busy_o(busy), .frame_cnt_o(frame_cnt), .err_o(err)
  );

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
  } cmd_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame-level busy/wait flags, expected command queue, outstanding count.
  cmd_t        exp_q[$];
  cmd_t        acc_log[$];
  bit          m_busy, m_wait, m_err, hold, sync_taken;
  int          m_out;
  logic [15:0] m_fc;
  cmd_t        held;

  function automatic void model_reset();
    exp_q.delete();
    m_busy = 0; m_wait = 0; m_err = 0; m_out = 0; m_fc = '0; hold = 0; sync_taken = 0;
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input int i);
    return ch_base[i*ADDR_W +: ADDR_W];
  endfunction

  // Compare outputs, advance the model with the inputs now applied, then step one clock.
  task automatic run_cycle();
    bit   fire;
    int   new_out;
    cmd_t obs, c;
    check("sync_ready", 96'(sync_ready), 96'(!m_busy));
    check("busy", 96'(busy), 96'(m_busy));
    check("frame_cnt", 96'(frame_cnt), 96'(m_fc));
    check("err", 96'(err), 96'(m_err));
    obs.ch = cmd_ch; obs.addr = cmd_addr; obs.len = cmd_len;
    if (hold) begin
      check("hold_valid", 96'(cmd_valid), 96'(1'b1));
      if (cmd_valid) check("hold_payload", 96'(obs), 96'(held));
    end
    if (cmd_valid) check("cmd_expected", 96'(exp_q.size() != 0), 96'(1'b1));
    fire = cmd_valid && cmd_ready;
    hold = cmd_valid && !cmd_ready;
    held = obs;
    if (fire) begin
      acc_log.push_back(obs);
      if (exp_q.size() != 0) begin
        check("cmd_payload", 96'(obs), 96'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    new_out = m_out;
    if (fire && !done) new_out++;
    else if (done && !fire) begin
      if (m_out == 0) m_err = 1;
      else new_out--;
    end
    if (!m_busy) begin
      if (sync_valid) begin
        sync_taken = 1;
        if (ch_enable != '0) begin
          m_busy = 1; m_wait = 0;
          for (int i = 0; i < CH_NUM; i++) begin
            if (ch_enable[i]) begin
              c.ch   = CH_W'(i);
              c.addr = base_of(i) + ADDR_W'(sync_fnum) * frame_size;
              c.len  = frame_size;
              exp_q.push_back(c);
            end
          end
        end
      end
    end else if (m_wait) begin
      if (new_out == 0) begin m_busy = 0; m_wait = 0; m_fc++; end
    end else if (fire && exp_q.size() == 0) begin
      m_wait = 1;
    end
    m_out = new_out;
    @(posedge clk); #1;
  endtask

  task automatic sync_once(input logic [CH_NUM-1:0] en, input logic [FN_W-1:0] fn);
    int k;
    ch_enable = en; sync_fnum = fn; sync_valid = 1'b1; sync_taken = 0;
    k = 0;
    while (!sync_taken && k < 50) begin run_cycle(); k++; end
    check("sync_timeout", 96'(sync_taken), 96'(1'b1));
    sync_valid = 1'b0; sync_taken = 0;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int k;
    k = 0;
    while (acc_log.size() < n && k < budget) begin run_cycle(); k++; end
    check("accept_timeout", 96'(acc_log.size() >= n), 96'(1'b1));
  endtask

  task automatic drain();
    int k;
    sync_valid = 1'b0; cmd_ready = 1'b1;
    k = 0;
    while ((m_busy || m_out > 0) && k < 200) begin
      done = (m_out > 0);
      run_cycle(); k++;
    end
    done = 1'b0;
    check("drain_timeout", 96'(m_busy), 96'(1'b0));
  endtask

  logic [15:0] fc_before;

  initial begin
    rstn = 1'b0; ch_enable = '0; ch_base = '0; frame_size = '0;
    sync_valid = 1'b0; sync_fnum = '0; cmd_ready = 1'b0; done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_valid", 96'(cmd_valid), 96'(1'b0));
    check("rst_cmd_addr", 96'(cmd_addr), 96'(0));
    run_cycle();

    // Three enabled channels, fnum 3, always ready.
    for (int i = 0; i < CH_NUM; i++) ch_base[i*ADDR_W +: ADDR_W] = ADDR_W'(i * 32'h10_0000);
    frame_size = 32'h1000; cmd_ready = 1'b1; acc_log.delete();
    sync_once(5'b10101, 3'd3);
    wait_accepts(3, 20);
    if (acc_log.size() >= 3) begin
      check("a_ch0", 96'(acc_log[0].ch), 96'(0));
      check("a_addr0", 96'(acc_log[0].addr), 96'(32'h0000_3000));
      check("a_ch1", 96'(acc_log[1].ch), 96'(2));
      check("a_addr1", 96'(acc_log[1].addr), 96'(32'h0020_3000));
      check("a_ch2", 96'(acc_log[2].ch), 96'(4));
      check("a_addr2", 96'(acc_log[2].addr), 96'(32'h0040_3000));
      check("a_len", 96'(acc_log[2].len), 96'(32'h1000));
    end
    done = 1'b1;
    repeat (3) run_cycle();
    done = 1'b0;
    repeat (2) run_cycle();
    check("a_frame_cnt", 96'(frame_cnt), 96'(16'd1));

    // Sync with nothing enabled is consumed without commands.
    sync_once('0, 3'd1);
    repeat (4) run_cycle();
    check("b_frame_cnt", 96'(frame_cnt), 96'(16'd1));

    // Backpressure on a single command for ten cycles.
    ch_base[0 +: ADDR_W] = 32'hABC0_0000; cmd_ready = 1'b0; acc_log.delete();
    sync_once(5'b00001, 3'd5);
    for (int k = 0; k < 10 && !cmd_valid; k++) run_cycle();
    repeat (10) run_cycle();
    check("c_no_early_accept", 96'(acc_log.size()), 96'(0));
    cmd_ready = 1'b1;
    run_cycle();
    check("c_accepted", 96'(acc_log.size()), 96'(1));
    if (acc_log.size() >= 1) check("c_addr", 96'(acc_log[0].addr), 96'(32'hABC0_5000));
    done = 1'b1; run_cycle(); done = 1'b0;
    repeat (2) run_cycle();

    // Completion landing in the same cycle as the second accept.
    fc_before = m_fc;
    sync_once(5'b00011, 3'd2);
    for (int k = 0; k < 20 && !m_wait; k++) begin
      done = cmd_valid && cmd_ready && (m_out == 1) && (exp_q.size() == 1);
      run_cycle();
    end
    done = 1'b0;
    run_cycle();
    check("d_still_busy", 96'(busy), 96'(1'b1));
    done = 1'b1; run_cycle(); done = 1'b0;
    repeat (2) run_cycle();
    check("d_frame_cnt", 96'(frame_cnt), 96'(fc_before + 16'd1));
    check("d_no_err", 96'(err), 96'(1'b0));

    // Random traffic, including enable changes while busy.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (sync_taken) begin sync_valid = 1'b0; sync_taken = 0; end
      if (!sync_valid && !m_busy && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < CH_NUM; i++) ch_base[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        frame_size = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(1, 16) * 4096);
      end
      if (!sync_valid && $urandom_range(0, 5) == 0) begin
        sync_valid = 1'b1;
        sync_fnum  = FN_W'($urandom);
        ch_enable  = ($urandom_range(0, 7) == 0) ? '0 : CH_NUM'($urandom);
      end else if (!sync_valid) begin
        ch_enable = CH_NUM'($urandom);
      end
      cmd_ready = ($urandom_range(0, 9) < 6);
      done = ((m_out > 0) || (cmd_valid && cmd_ready)) && ($urandom_range(0, 2) == 0);
      run_cycle();
    end
    done = 1'b0;
    if (sync_taken) begin sync_valid = 1'b0; sync_taken = 0; end
    drain();
    run_cycle();

    // Stray completion while idle sets a sticky error.
    done = 1'b1; run_cycle(); done = 1'b0;
    repeat (3) run_cycle();
    check("e_err_sticky", 96'(err), 96'(1'b1));
    check("e_idle", 96'(sync_ready), 96'(1'b1));

    // Reset in WAIT with two outstanding, then a clean dispatch.
    cmd_ready = 1'b1; acc_log.delete();
    sync_once(5'b00111, 3'd2);
    wait_accepts(3, 20);
    done = 1'b1; run_cycle(); done = 1'b0;
    check("f_in_wait", 96'(busy), 96'(1'b1));
    #2 rstn = 1'b0;
    #1;
    check("f_rst_cmd_valid", 96'(cmd_valid), 96'(1'b0));
    check("f_rst_cmd_ch", 96'(cmd_ch), 96'(0));
    check("f_rst_cmd_addr", 96'(cmd_addr), 96'(0));
    check("f_rst_cmd_len", 96'(cmd_len), 96'(0));
    check("f_rst_busy", 96'(busy), 96'(1'b0));
    check("f_rst_frame_cnt", 96'(frame_cnt), 96'(0));
    check("f_rst_err", 96'(err), 96'(1'b0));
    check("f_rst_sync_ready", 96'(sync_ready), 96'(1'b1));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    model_reset();
    run_cycle();
    ch_base[0 +: ADDR_W] = 32'h1234_0000; frame_size = 32'h800; acc_log.delete();
    sync_once(5'b00001, 3'd7);
    wait_accepts(1, 20);
    if (acc_log.size() >= 1) check("f_addr", 96'(acc_log[0].addr), 96'(32'h1234_3800));
    done = 1'b1; run_cycle(); done = 1'b0;
    repeat (2) run_cycle();
    check("f_frame_cnt", 96'(frame_cnt), 96'(16'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
